phase_sweep_sequencer: RTL and testbench

Sequences a multi-phase depth capture. For each of num_phases phase offsets, the block triggers one frame on the frame grabber and waits for it to finish. It then advances the modulation PLL phase by steps_per_phase PHASE_STEP handshakes and lets the PLL settle before the next frame. It sits between the Avalon register block and the frame grabber/PLL reconfig pins, so software issues a single start instead of bit-banging frame_start and phase steps.

---
 rtl/phase_sweep_sequencer.sv | 157 +++++++++++++++
 tb/tb_phase_sweep_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sweep_sequencer.sv
// Multi-phase depth capture sequencer: fires one frame per phase, then steps the
// modulation PLL phase and lets it settle before the next frame.
module phase_sweep_sequencer #(
  parameter int STEP_PULSE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int PHASE_WIDTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] num_phases,
  input  logic [PHASE_WIDTH-1:0] steps_per_phase,
  input  logic [15:0]            settle_cycles,
  output logic                   frame_start,
  input  logic                   frame_rdy,
  input  logic                   frame_done,
  output logic                   phase_step,
  input  logic                   phase_done,
  output logic                   busy,
  output logic [PHASE_WIDTH-1:0] phase_index,
  output logic                   frame_captured,
  output logic                   sweep_done,
  output logic                   error,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    FIRE      = 3'd2,
    WAIT_DONE = 3'd3,
    STEP      = 3'd4,
    WAIT_STEP = 3'd5,
    SETTLE    = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t                 state, state_nxt;
  logic [PHASE_WIDTH-1:0] num_q, steps_q, step_cnt, last_index;
  logic [15:0]            settle_q, cnt;
  logic                   accept, timeout, load_step, dec_step, adv_phase, tmo_hit;

  // cnt restarts on every state entry; it times the step pulse, the settle
  // delay and the wait-state timeout.
  assign tmo_hit    = (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign last_index = num_q - PHASE_WIDTH'(1);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Handshakes: frame_start is a one-cycle request answered by frame_done (level,
  // accepted only in WAIT_DONE); phase_step is a fixed-width pulse answered by
  // phase_done, which is ignored during the first WAIT_STEP cycle while the PLL
  // is still pulling it low.
  always_comb begin
    state_nxt      = state;
    frame_start    = 1'b0;
    phase_step     = 1'b0;
    frame_captured = 1'b0;
    sweep_done     = 1'b0;
    accept         = 1'b0;
    timeout        = 1'b0;
    load_step      = 1'b0;
    dec_step       = 1'b0;
    adv_phase      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          accept    = 1'b1;
          state_nxt = WAIT_RDY;
        end
        WAIT_RDY: begin
          if (num_q == '0)    state_nxt = FINISH;
          else if (frame_rdy) state_nxt = FIRE;
          else if (tmo_hit) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
        FIRE: begin
          frame_start = 1'b1;
          state_nxt   = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (frame_done) begin
            frame_captured = 1'b1;
            if (phase_index == last_index) state_nxt = FINISH;
            else if (steps_q == '0)        state_nxt = SETTLE;
            else begin
              load_step = 1'b1;
              state_nxt = STEP;
            end
          end else if (tmo_hit) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
        STEP: begin
          phase_step = 1'b1;
          if (cnt == 16'(STEP_PULSE_CYCLES - 1)) state_nxt = WAIT_STEP;
        end
        WAIT_STEP: begin
          if (cnt != 16'd0 && phase_done) begin
            dec_step  = 1'b1;
            state_nxt = (step_cnt == PHASE_WIDTH'(1)) ? SETTLE : STEP;
          end else if (tmo_hit) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
        end
        SETTLE: if (settle_q == 16'd0 || cnt == settle_q - 16'd1) begin
          adv_phase = 1'b1;
          state_nxt = WAIT_RDY;
        end
        FINISH: begin
          sweep_done = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      num_q       <= '0;
      steps_q     <= '0;
      settle_q    <= '0;
      step_cnt    <= '0;
      phase_index <= '0;
      error       <= 1'b0;
    end else begin
      if (state_nxt != state || state_nxt == IDLE) cnt <= '0;
      else                                         cnt <= cnt + 16'd1;
      if (accept) begin
        num_q       <= num_phases;
        steps_q     <= steps_per_phase;
        settle_q    <= settle_cycles;
        phase_index <= '0;
        error       <= 1'b0;
      end
      if (timeout) error <= 1'b1;
      if (load_step)     step_cnt <= steps_q;
      else if (dec_step) step_cnt <= step_cnt - PHASE_WIDTH'(1);
      if (adv_phase) phase_index <= phase_index + PHASE_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_phase_sweep_sequencer.sv
// Directed bench for phase_sweep_sequencer with behavioural frame grabber and PLL models.
module tb_phase_sweep_sequencer;

  localparam int FRAME_LAT = 20;
  localparam int PLL_LAT   = 4;

  logic        clock, reset_n, start, abort, frame_rdy, frame_done, phase_done;
  logic [7:0]  num_phases, steps_per_phase, phase_index;
  logic [15:0] settle_cycles;
  logic        frame_start, phase_step, busy, frame_captured, sweep_done, error;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  phase_sweep_sequencer #(
    .STEP_PULSE_CYCLES(3),
    .TIMEOUT_CYCLES(100),
    .PHASE_WIDTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .num_phases(num_phases), .steps_per_phase(steps_per_phase),
    .settle_cycles(settle_cycles), .frame_start(frame_start),
    .frame_rdy(frame_rdy), .frame_done(frame_done), .phase_step(phase_step),
    .phase_done(phase_done), .busy(busy), .phase_index(phase_index),
    .frame_captured(frame_captured), .sweep_done(sweep_done), .error(error),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // frame grabber and PLL models, updated 2 time units after each edge
  int   fg_cnt = 0;
  int   pll_cnt = 0;
  logic fg_done_r = 1'b0;
  logic step_prev = 1'b0;
  logic pll_stuck = 1'b0;
  always @(posedge clock) begin
    #2;
    fg_done_r = 1'b0;
    if (frame_start) fg_cnt = FRAME_LAT;
    else if (fg_cnt != 0) begin
      fg_cnt--;
      if (fg_cnt == 0) fg_done_r = 1'b1;
    end
    if (phase_step && !step_prev) pll_cnt = PLL_LAT;
    else if (pll_cnt != 0) pll_cnt--;
    step_prev = phase_step;
  end
  assign frame_done = fg_done_r;
  assign phase_done = (pll_cnt == 0) && !pll_stuck;

  // scoreboard: monitor records events at the falling edge
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_fs = 0, n_ps = 0, n_ps_bad = 0, n_sd = 0, ps_run = 0;
  always @(negedge clock) begin
    if (frame_start) n_fs++;
    if (sweep_done) n_sd++;
    if (frame_captured) got_q.push_back(phase_index);
    if (phase_step) ps_run++;
    else if (ps_run != 0) begin
      n_ps++;
      if (ps_run != 3) n_ps_bad++;
      ps_run = 0;
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [7:0] np, input logic [7:0] sp, input logic [15:0] sc);
    @(posedge clock); #1;
    num_phases = np; steps_per_phase = sp; settle_cycles = sc; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_step_on_phase(input logic [7:0] idx, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (phase_step && phase_index == idx) begin ok = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; frame_rdy = 1'b1;
    num_phases = '0; steps_per_phase = '0; settle_cycles = '0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%0b exp=0", frame_start); end
    total++; if (phase_step !== 1'b0) begin bad++; $display("FAIL reset_phase_step got=%0b exp=0", phase_step); end
    total++; if (phase_index !== 8'd0) begin bad++; $display("FAIL reset_phase_index got=%0d exp=0", phase_index); end
    total++; if ({frame_captured, sweep_done, error} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {frame_captured, sweep_done, error}); end
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_nominal();
    int fs0 = n_fs, ps0 = n_ps, pb0 = n_ps_bad, sd0 = n_sd, g0 = got_q.size();
    bit ok;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    pulse_start(8'd4, 8'd2, 16'd10);
    total++; if (frame_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL nom_cycle1 got fs=%0b busy=%0b exp fs=0 busy=1", frame_start, busy); end
    @(posedge clock); #1;
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL nom_first_fire got=%0b exp=1", frame_start); end
    wait_idle(2000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL nom_timeout got=busy exp=idle"); end
    repeat (3) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 4) begin bad++; $display("FAIL nom_frames got=%0d exp=4", n_fs - fs0); end
    total++; if (n_ps - ps0 !== 6) begin bad++; $display("FAIL nom_steps got=%0d exp=6", n_ps - ps0); end
    total++; if (n_ps_bad - pb0 !== 0) begin bad++; $display("FAIL nom_step_width got=%0d exp=0", n_ps_bad - pb0); end
    total++; if (n_sd - sd0 !== 1) begin bad++; $display("FAIL nom_sweep_done got=%0d exp=1", n_sd - sd0); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL nom_error got=%0b exp=0", error); end
    total++; if (got_q.size() - g0 !== exp_q.size()) begin bad++; $display("FAIL nom_captured_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size()) begin
        total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL nom_index[%0d] got=%0d exp=%0d", i, got_q[g0+i], exp_q[i]); end
      end
    repeat (30) @(posedge clock); #1;
  endtask

  task automatic test_zero_phases();
    int fs0 = n_fs, ps0 = n_ps;
    pulse_start(8'd0, 8'd3, 16'd5);
    total++; if (sweep_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL zero_cycle1 got sd=%0b busy=%0b exp sd=0 busy=1", sweep_done, busy); end
    @(posedge clock); #1;
    total++; if (sweep_done !== 1'b1) begin bad++; $display("FAIL zero_sweep_done got=%0b exp=1", sweep_done); end
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%0b exp=0", busy); end
    repeat (5) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 0 || n_ps - ps0 !== 0) begin bad++; $display("FAIL zero_no_activity got fs=%0d ps=%0d exp 0 0", n_fs - fs0, n_ps - ps0); end
  endtask

  task automatic test_no_steps();
    int fs0 = n_fs, ps0 = n_ps, sd0 = n_sd, g0 = got_q.size();
    bit ok;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    frame_rdy = 1'b0;
    pulse_start(8'd3, 8'd0, 16'd0);
    repeat (10) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 0 || busy !== 1'b1) begin bad++; $display("FAIL nostep_rdy_gate got fs=%0d busy=%0b exp fs=0 busy=1", n_fs - fs0, busy); end
    frame_rdy = 1'b1;
    wait_idle(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL nostep_timeout got=busy exp=idle"); end
    repeat (3) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 3) begin bad++; $display("FAIL nostep_frames got=%0d exp=3", n_fs - fs0); end
    total++; if (n_ps - ps0 !== 0) begin bad++; $display("FAIL nostep_steps got=%0d exp=0", n_ps - ps0); end
    total++; if (n_sd - sd0 !== 1) begin bad++; $display("FAIL nostep_sweep_done got=%0d exp=1", n_sd - sd0); end
    total++; if (got_q.size() - g0 !== exp_q.size()) begin bad++; $display("FAIL nostep_captured_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size()) begin
        total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL nostep_index[%0d] got=%0d exp=%0d", i, got_q[g0+i], exp_q[i]); end
      end
    repeat (30) @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    int sd0 = n_sd, k = 0;
    bit ok;
    pll_stuck = 1'b1;
    pulse_start(8'd2, 8'd1, 16'd0);
    wait_step_on_phase(8'd0, 200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tmo_no_step got=none exp=step"); end
    while (busy && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    total++; if (k < 100 || k > 106) begin bad++; $display("FAIL tmo_latency got=%0d exp=100..106", k); end
    total++; if (error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_error got err=%0b busy=%0b exp err=1 busy=0", error, busy); end
    repeat (5) @(posedge clock); #1;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0b exp=1", error); end
    total++; if (n_sd - sd0 !== 0) begin bad++; $display("FAIL tmo_sweep_done got=%0d exp=0", n_sd - sd0); end
    pll_stuck = 1'b0;
    pulse_start(8'd1, 8'd0, 16'd0);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%0b exp=0", error); end
    wait_idle(500, ok);
    total++; if (ok !== 1'b1 || n_sd - sd0 !== 1) begin bad++; $display("FAIL tmo_recover got sd=%0d exp=1", n_sd - sd0); end
    repeat (30) @(posedge clock); #1;
  endtask

  task automatic test_abort();
    int fs0 = n_fs, ps0 = n_ps, pb0 = n_ps_bad, sd0 = n_sd, g0 = got_q.size();
    bit ok;
    exp_q.delete();
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    pulse_start(8'd3, 8'd2, 16'd2);
    wait_step_on_phase(8'd1, 1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_no_step got=none exp=step"); end
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    total++; if (phase_step !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got ps=%0b busy=%0b exp 0 0", phase_step, busy); end
    num_phases = 8'd2; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_wins_start got=%0b exp=0", busy); end
    repeat (30) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 2) begin bad++; $display("FAIL abort_frames got=%0d exp=2", n_fs - fs0); end
    total++; if (n_ps - ps0 !== 3 || n_ps_bad - pb0 !== 1) begin bad++; $display("FAIL abort_steps got=%0d/%0d exp=3/1", n_ps - ps0, n_ps_bad - pb0); end
    total++; if (n_sd - sd0 !== 0 || error !== 1'b0) begin bad++; $display("FAIL abort_no_done got sd=%0d err=%0b exp 0 0", n_sd - sd0, error); end
    total++; if (got_q.size() - g0 !== exp_q.size()) begin bad++; $display("FAIL abort_captured_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size()) begin
        total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL abort_index[%0d] got=%0d exp=%0d", i, got_q[g0+i], exp_q[i]); end
      end
  endtask

  task automatic test_back_to_back();
    int fs0 = n_fs, ps0 = n_ps, sd0 = n_sd, g0 = got_q.size();
    bit ok;
    pulse_start(8'd2, 8'd1, 16'd3);
    repeat (5) @(posedge clock); #1;
    num_phases = 8'd7; steps_per_phase = 8'd5; settle_cycles = 16'd50; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=busy exp=idle"); end
    repeat (3) @(posedge clock); #1;
    total++; if (n_fs - fs0 !== 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", n_fs - fs0); end
    total++; if (n_ps - ps0 !== 1) begin bad++; $display("FAIL b2b_steps got=%0d exp=1", n_ps - ps0); end
    total++; if (n_sd - sd0 !== 1) begin bad++; $display("FAIL b2b_sweep_done got=%0d exp=1", n_sd - sd0); end
    total++; if (got_q.size() - g0 !== 2) begin bad++; $display("FAIL b2b_captured got=%0d exp=2", got_q.size() - g0); end
    repeat (30) @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    pulse_start(8'd3, 8'd1, 16'd0);
    wait_step_on_phase(8'd1, 1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_no_step got=none exp=step"); end
    reset_n = 1'b0;
    #1;
    total++; if ({frame_start, phase_step, busy, frame_captured, sweep_done, error} !== 6'b0) begin bad++; $display("FAIL rstmid_outputs got=%b exp=000000", {frame_start, phase_step, busy, frame_captured, sweep_done, error}); end
    total++; if (phase_index !== 8'd0) begin bad++; $display("FAIL rstmid_phase_index got=%0d exp=0", phase_index); end
    #2;
    reset_n = 1'b1;
    repeat (30) @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_phases();
    test_no_steps();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
